// File: rtl/fifo64_if.sv
// ---------------------------------------------------------------------------
// fifo64_if -- push/pop bundle for the fifo64 buffer.
//
// Signals:
//   i_write  push request, sampled at the rising clock edge
//   i_wdata  word to push when the push is accepted
//   i_read   pop request, sampled at the rising clock edge
//   o_rdata  registered head word from the most recent accepted pop
//   o_empty  registered, 1 when occupancy is 0
//   o_full   registered, 1 when occupancy equals DEPTH
//
// Handshake: a push is accepted on a rising edge when i_write is 1 and the
// FIFO is not full, or when it is full but a pop is accepted on that same
// edge. A pop is accepted on a rising edge when i_read is 1 and o_empty is 0.
// Requests that are not accepted are dropped, not held; the requester reads
// o_empty/o_full to know whether a request will be taken. Popped data is
// valid on o_rdata from the cycle after the accepting edge and holds until
// the next accepted pop.
//
// Modports: master = producer/consumer side, slave = the FIFO.
// ---------------------------------------------------------------------------
interface fifo64_if #(
   parameter int WIDTH = 32
);
   logic             i_write;
   logic [WIDTH-1:0] i_wdata;
   logic             i_read;
   logic [WIDTH-1:0] o_rdata;
   logic             o_empty;
   logic             o_full;

   modport master (
      output i_write, i_wdata, i_read,
      input  o_rdata, o_empty, o_full
   );

   modport slave (
      input  i_write, i_wdata, i_read,
      output o_rdata, o_empty, o_full
   );
endinterface

// File: rtl/fifo64.sv
// ---------------------------------------------------------------------------
// fifo64 -- synchronous single-clock FIFO with registered read data and
// registered empty/full flags.
//
// Parameters:
//   DEPTH  number of entries, power of two, >= 2
//   WIDTH  data word width in bits
//
// Ports:
//   i_clock  rising-edge clock
//   i_reset  asynchronous, active-high reset
//   bus      fifo64_if slave modport (push/pop requests, read data, flags)
// ---------------------------------------------------------------------------
module fifo64 #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 32
) (
   input  logic          i_clock,
   input  logic          i_reset,
   fifo64_if.slave       bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic [AW:0]      count_next;
   logic             wr_ok;
   logic             rd_ok;

   // A full FIFO can still take a push when a pop frees a slot on the same
   // edge; an empty FIFO never honours a pop, even alongside a push.
   assign rd_ok = bus.i_read & ~bus.o_empty;
   assign wr_ok = bus.i_write & (~bus.o_full | rd_ok);

   always_comb begin
      count_next = count;
      case ({wr_ok, rd_ok})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // Storage is not reset; its contents are don't-care until written.
   always_ff @(posedge i_clock) begin
      if (wr_ok) begin
         mem[wptr] <= bus.i_wdata;
      end
   end

   // The read of mem[rptr] uses the pre-edge contents, so at full occupancy
   // a simultaneous push into the same slot still returns the old word.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         bus.o_rdata <= '0;
         bus.o_empty <= 1'b1;
         bus.o_full  <= 1'b0;
      end else begin
         if (wr_ok) begin
            wptr <= wptr + 1'b1;
         end
         if (rd_ok) begin
            rptr        <= rptr + 1'b1;
            bus.o_rdata <= mem[rptr];
         end
         count       <= count_next;
         bus.o_empty <= (count_next == '0);
         bus.o_full  <= (count_next == FULL_COUNT);
      end
   end
endmodule

// File: tb/tb_fifo64.sv
// ---------------------------------------------------------------------------
// tb_fifo64 -- self-checking bench for fifo64 (DEPTH=4, WIDTH=8).
// A queue-based reference model tracks contents, flags and the last popped
// word; every cycle the DUT outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_fifo64;
   localparam int DEPTH = 4;
   localparam int WIDTH = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo64_if #(.WIDTH(WIDTH)) bus ();

   fifo64 #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus.slave)
   );

   // ---------------- scoreboard / model ----------------
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] exp_rdata = '0;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".rdata"}, 32'(bus.o_rdata), 32'(exp_rdata));
      check({tag, ".empty"}, 32'(bus.o_empty), 32'(exp_q.size() == 0));
      check({tag, ".full"},  32'(bus.o_full),  32'(exp_q.size() == DEPTH));
   endtask

   // ---------------- driver ----------------
   // Apply one cycle of requests, let the edge happen, update the model from
   // the acceptance rules, then compare just after the edge.
   task automatic cycle(input string tag, input logic w,
                        input logic [WIDTH-1:0] wd, input logic r);
      logic pop_ok;
      logic push_ok;
      bus.i_write = w;
      bus.i_wdata = wd;
      bus.i_read  = r;
      @(posedge clk);
      pop_ok  = r && (exp_q.size() > 0);
      push_ok = w && ((exp_q.size() < DEPTH) || pop_ok);
      if (pop_ok)  exp_rdata = exp_q.pop_front();
      if (push_ok) exp_q.push_back(wd);
      #1;
      bus.i_write = 1'b0;
      bus.i_read  = 1'b0;
      check_outputs(tag);
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_rdata = '0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      bus.i_write = 1'b0;
      bus.i_wdata = '0;
      bus.i_read  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      #3 rst = 1'b0;
      @(posedge clk); #1;
      check_outputs("idle");

      // Two pushes, one idle, two pops
      cycle("push_a5", 1'b1, 8'hA5, 1'b0);
      cycle("push_3c", 1'b1, 8'h3C, 1'b0);
      cycle("gap",     1'b0, 8'h00, 1'b0);
      cycle("pop_a5",  1'b0, 8'h00, 1'b1);
      cycle("pop_3c",  1'b0, 8'h00, 1'b1);
      check("pop_3c.value", 32'(bus.o_rdata), 32'h3C);

      // Pop while empty: ignored, rdata holds
      cycle("pop_empty", 1'b0, 8'h00, 1'b1);
      cycle("pop_empty2", 1'b0, 8'h00, 1'b1);
      cycle("push_after_empty", 1'b1, 8'h77, 1'b0);
      cycle("pop_after_empty", 1'b0, 8'h00, 1'b1);
      check("pop_after_empty.value", 32'(bus.o_rdata), 32'h77);

      // Fill, overflow drop, drain
      for (int i = 1; i <= 4; i++) cycle("fill", 1'b1, 8'(i), 1'b0);
      cycle("overflow_drop", 1'b1, 8'd5, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         cycle("drain", 1'b0, 8'h00, 1'b1);
         check("drain.value", 32'(bus.o_rdata), 32'(i));
      end

      // Empty + simultaneous push/pop: pop ignored, push taken
      cycle("empty_both", 1'b1, 8'h42, 1'b1);
      cycle("empty_both_pop", 1'b0, 8'h00, 1'b1);
      check("empty_both.value", 32'(bus.o_rdata), 32'h42);

      // Full + simultaneous push/pop: both taken, old head returned
      for (int i = 1; i <= 4; i++) cycle("refill", 1'b1, 8'(i), 1'b0);
      cycle("full_both", 1'b1, 8'd9, 1'b1);
      check("full_both.value", 32'(bus.o_rdata), 32'd1);
      for (int i = 0; i < 4; i++) cycle("full_both_drain", 1'b0, 8'h00, 1'b1);
      check("full_both.last", 32'(bus.o_rdata), 32'd9);

      // Wrap-around streaming with occupancy 1..2
      cycle("wrap", 1'b1, 8'd10, 1'b0);
      cycle("wrap", 1'b1, 8'd11, 1'b0);
      for (int i = 12; i < 20; i++) cycle("wrap", 1'b1, 8'(i), 1'b1);
      cycle("wrap", 1'b0, 8'h00, 1'b1);
      cycle("wrap", 1'b0, 8'h00, 1'b1);
      check("wrap.last", 32'(bus.o_rdata), 32'd19);

      // Randomized traffic with varying push/pop bias
      for (int i = 0; i < 400; i++) begin
         int bias;
         bias = (i / 50) % 3;
         cycle("rand",
               ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5))),
               8'($urandom),
               ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5))));
      end

      // Asynchronous reset mid-operation, checked before the next edge
      for (int i = 0; i < 3; i++) cycle("pre_reset", 1'b1, 8'($urandom), 1'b0);
      cycle("pre_reset_pop", 1'b0, 8'h00, 1'b1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs("async_reset");
      @(posedge clk); #1;
      check_outputs("reset_hold");
      #2 rst = 1'b0;
      for (int i = 0; i < 60; i++)
         cycle("post_reset", ($urandom_range(0, 1) == 1), 8'($urandom),
               ($urandom_range(0, 1) == 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
